// File: rtl/aes_pkg.sv
// AES state types and ShiftRows index helpers shared by the byte-serial and parallel row-shift paths.
// Latency: none, purely combinational helpers.
// Backpressure: not applicable.
package aes_pkg;

    localparam int NB          = 4;
    localparam int STATE_BYTES = 16;

    typedef logic [7:0]       byte_t;
    typedef byte_t [15:0]     state_t;

    // Source byte for InvShiftRows: row r is rotated right by r, so output
    // column c takes input column (c - r) mod 4. The 2-bit column field
    // wraps naturally.
    function automatic logic [3:0] inv_sr_idx(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] sc;
        r  = k[1:0];
        c  = k[3:2];
        sc = c - r;
        return {sc, r};
    endfunction

    // Source byte for forward ShiftRows: row r rotated left by r.
    function automatic logic [3:0] fwd_sr_idx(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] sc;
        r  = k[1:0];
        c  = k[3:2];
        sc = c + r;
        return {sc, r};
    endfunction

endpackage

// File: rtl/sr_index_map.sv
// Maps an output byte position to the buffered input position for (Inv)ShiftRows.
// Latency: combinational.
// Backpressure: not applicable.
module sr_index_map
    import aes_pkg::*;
(
    input  logic [3:0] k,
    input  logic       fwd,
    output logic [3:0] src
);

    assign src = fwd ? fwd_sr_idx(k) : inv_sr_idx(k);

endmodule

// File: rtl/inv_shiftrows_stream.sv
// Byte-serial AES InvShiftRows with ping-pong 16-byte banks; optional forward mode via SR_FWD_MODE_EN.
// Latency: first output byte is valid the cycle after the 16th input byte is accepted.
// Backpressure: valid/ready both sides; s_ready drops while the write bank is full, output holds while m_ready is low.
module inv_shiftrows_stream
    import aes_pkg::*;
#(
    parameter int BYTE_W  = 8,
    parameter int NUM_BUF = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SR_FWD_MODE_EN
    input  logic              fwd,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last
);

    // Two banks are always declared; with NUM_BUF=1 the pointers never
    // leave bank 0, so bank 1 stays at its reset value.
    logic [BYTE_W-1:0] bank [2][STATE_BYTES];
    logic [1:0]        full;
    logic              wr_sel;
    logic              rd_sel;
    logic [3:0]        wr_cnt;
    logic [3:0]        rd_cnt;
    logic              s_fire;
    logic              m_fire;
    logic              wr_done;
    logic              rd_done;
    logic              rd_fwd;
    logic [3:0]        rd_src;

    assign s_ready = !full[wr_sel] && !reset;
    assign m_valid = full[rd_sel] && !reset;
    assign m_last  = m_valid && (rd_cnt == 4'd15);
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign wr_done = s_fire && (wr_cnt == 4'd15);
    assign rd_done = m_fire && (rd_cnt == 4'd15);

`ifdef SR_FWD_MODE_EN
    logic [1:0] tag;

    // Direction tag is captured with byte 0 and travels with the bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
        end else if (s_fire && (wr_cnt == 4'd0)) begin
            tag[wr_sel] <= fwd;
        end
    end

    assign rd_fwd = tag[rd_sel];
`else
    assign rd_fwd = 1'b0;
`endif

    sr_index_map u_map (
        .k   (rd_cnt),
        .fwd (rd_fwd),
        .src (rd_src)
    );

    assign m_data = reset ? '0 : bank[rd_sel][rd_src];

    // Bank storage: bytes land in arrival order; the permutation is applied on read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < STATE_BYTES; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (s_fire) begin
            bank[wr_sel][wr_cnt] <= s_data;
        end
    end

    // Write pointer and byte counter; move to the other bank after byte 15.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (s_fire) begin
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_done && (NUM_BUF == 2)) begin
                wr_sel <= ~wr_sel;
            end
        end
    end

    // Read pointer and byte counter; frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            rd_sel <= 1'b0;
        end else if (m_fire) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_done && (NUM_BUF == 2)) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    // Full flags: set on write completion, clear on read completion. A set
    // needs the bank empty and a clear needs it full, so the two never hit
    // the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (rd_done) begin
                full[rd_sel] <= 1'b0;
            end
            if (wr_done) begin
                full[wr_sel] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
module tb_inv_shiftrows_stream;

    typedef logic [7:0] blk_t [16];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       s_valid_v = '0;
    logic [1:0]       m_ready_v = '0;
    logic [1:0][7:0]  s_data_v = '0;
    logic [1:0]       s_ready_v;
    logic [1:0]       m_valid_v;
    logic [1:0]       m_last_v;
    logic [1:0][7:0]  m_data_v;
`ifdef SR_FWD_MODE_EN
    logic [1:0]       fwd_v = '0;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] expq0[$];
    logic [8:0] expq1[$];
    logic [7:0] obs0[$];
    logic [7:0] obs1[$];
    logic [8:0] e0;
    logic [8:0] e1;
    bit         bp_done;

    blk_t basic_exp = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                        8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
    blk_t fwd_exp   = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                        8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

    always #5 clk = ~clk;

    inv_shiftrows_stream #(.BYTE_W(8), .NUM_BUF(2)) dut0 (
        .clk     (clk),
        .reset   (reset),
`ifdef SR_FWD_MODE_EN
        .fwd     (fwd_v[0]),
`endif
        .s_valid (s_valid_v[0]),
        .s_ready (s_ready_v[0]),
        .s_data  (s_data_v[0]),
        .m_valid (m_valid_v[0]),
        .m_ready (m_ready_v[0]),
        .m_data  (m_data_v[0]),
        .m_last  (m_last_v[0])
    );

    inv_shiftrows_stream #(.BYTE_W(8), .NUM_BUF(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
`ifdef SR_FWD_MODE_EN
        .fwd     (fwd_v[1]),
`endif
        .s_valid (s_valid_v[1]),
        .s_ready (s_ready_v[1]),
        .s_data  (s_data_v[1]),
        .m_valid (m_valid_v[1]),
        .m_ready (m_ready_v[1]),
        .m_data  (m_data_v[1]),
        .m_last  (m_last_v[1])
    );

    // Reference map written from the row/column definition.
    function automatic int model_src(input int k, input bit f);
        int r;
        int c;
        r = k % 4;
        c = k / 4;
        if (f) return r + 4 * ((c + r) % 4);
        return r + 4 * ((c - r + 4) % 4);
    endfunction

    function automatic blk_t ramp(input int base);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 8'(base + i);
        return b;
    endfunction

    function automatic void push_block(input int d, input blk_t blk, input bit f);
        logic [8:0] v;
        for (int k = 0; k < 16; k++) begin
            v = {(k == 15), blk[model_src(k, f)]};
            if (d == 0) expq0.push_back(v);
            else        expq1.push_back(v);
        end
    endfunction

    // Scoreboard for the NUM_BUF=2 instance.
    always @(negedge clk) begin
        if (!reset && m_valid_v[0] && m_ready_v[0]) begin
            checks++;
            if (expq0.size() == 0) begin
                errors++;
                $display("FAIL out0_unexpected: got data=%02h last=%0b, expected no output", m_data_v[0], m_last_v[0]);
            end else begin
                e0 = expq0.pop_front();
                if ({m_last_v[0], m_data_v[0]} !== e0) begin
                    errors++;
                    $display("FAIL out0_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                             m_last_v[0], m_data_v[0], e0[8], e0[7:0]);
                end
            end
            obs0.push_back(m_data_v[0]);
        end
    end

    // Scoreboard for the NUM_BUF=1 instance.
    always @(negedge clk) begin
        if (!reset && m_valid_v[1] && m_ready_v[1]) begin
            checks++;
            if (expq1.size() == 0) begin
                errors++;
                $display("FAIL out1_unexpected: got data=%02h last=%0b, expected no output", m_data_v[1], m_last_v[1]);
            end else begin
                e1 = expq1.pop_front();
                if ({m_last_v[1], m_data_v[1]} !== e1) begin
                    errors++;
                    $display("FAIL out1_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                             m_last_v[1], m_data_v[1], e1[8], e1[7:0]);
                end
            end
            obs1.push_back(m_data_v[1]);
        end
    end

    // Present n bytes to instance d; expectations are queued once a full block is in.
    task automatic feed(input int d, input blk_t blk, input int n, input bit f,
                        output bit ok, output int stalls);
        bit got;
        stalls = 0;
        ok = 1;
        for (int k = 0; k < n && ok; k++) begin
            s_valid_v[d] = 1'b1;
            s_data_v[d]  = blk[k];
`ifdef SR_FWD_MODE_EN
            fwd_v[d] = (k == 0) ? f : ~f;
`endif
            got = 0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                if (s_ready_v[d]) got = 1;
                else stalls++;
                @(posedge clk);
                #1;
            end
            if (!got) ok = 0;
        end
        s_valid_v[d] = 1'b0;
        if (ok && n == 16) push_block(d, blk, f);
    endtask

    task automatic wait_drain(input int d, output bit ok);
        ok = 0;
        for (int t = 0; t < 600 && !ok; t++) begin
            @(posedge clk);
            #1;
            if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) ok = 1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid_v !== 2'b00 || m_last_v !== 2'b00 || s_ready_v !== 2'b00 || m_data_v !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got m_valid=%b m_last=%b s_ready=%b m_data=%h, expected all zero",
                     m_valid_v, m_last_v, s_ready_v, m_data_v);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready_v !== 2'b11 || m_valid_v !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b m_valid=%b, expected s_ready=11 m_valid=00", s_ready_v, m_valid_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        bit ok;
        int st;
        int bad;
        m_ready_v[0] = 1'b1;
        obs0.delete();
        feed(0, ramp(0), 16, 0, ok, st);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_feed: got input timeout, expected 16 accepts"); end
        @(negedge clk);
        checks++;
        if (m_valid_v[0] !== 1'b1 || m_data_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL basic_latency: got m_valid=%b m_data=%02h, expected 1 and 00", m_valid_v[0], m_data_v[0]);
        end
        wait_drain(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_drain: got %0d pending, expected 0", expq0.size()); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (i >= obs0.size() || obs0[i] !== basic_exp[i]) bad++;
        checks++;
        if (bad != 0 || obs0.size() != 16) begin
            errors++;
            $display("FAIL basic_sequence: got %0d bytes with %0d wrong, expected 16 matching", obs0.size(), bad);
        end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2, ok, seen;
        int st1, st2, gaps, bad;
        blk_t lit;
        lit[0] = 8'h10; lit[1] = 8'h1d; lit[2] = 8'h1a; lit[3] = 8'h17;
        m_ready_v[0] = 1'b1;
        obs0.delete();
        gaps = 0;
        seen = 0;
        fork
            begin
                feed(0, ramp(8'h00), 16, 0, ok1, st1);
                feed(0, ramp(8'h10), 16, 0, ok2, st2);
            end
            begin
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (m_valid_v[0]) seen = 1;
                end
                for (int i = 1; i < 32; i++) begin
                    @(negedge clk);
                    if (!m_valid_v[0]) gaps++;
                end
            end
        join
        checks++;
        if (!ok1 || !ok2 || st1 + st2 != 0) begin
            errors++;
            $display("FAIL b2b_s_ready: got %0d stall cycles, expected 0", st1 + st2);
        end
        checks++;
        if (!seen || gaps != 0) begin
            errors++;
            $display("FAIL b2b_gaps: got seen=%0b gaps=%0d, expected seen=1 gaps=0", seen, gaps);
        end
        wait_drain(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d pending, expected 0", expq0.size()); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (obs0.size() < 20 || obs0[16 + i] !== lit[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_second_head: got %0d wrong of first 4 bytes, expected 10 1d 1a 17", bad);
        end
    endtask

    task automatic test_backpressure;
        bit ok_a, ok_b, ok_c, ok, early;
        bit pv, pr, pl;
        logic [7:0] pd;
        int st, fires;
        bp_done = 0;
        pv = 0; pr = 0; pl = 0; pd = '0;
        fork
            begin
                feed(0, ramp(8'h20), 16, 0, ok_a, st);
                feed(0, ramp(8'h30), 16, 0, ok_b, st);
                feed(0, ramp(8'h60), 16, 0, ok_c, st);
                wait_drain(0, ok);
                bp_done = 1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    m_ready_v[0] = 1'($urandom_range(0, 1));
                end
            end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        checks++;
                        if (m_valid_v[0] !== 1'b1 || m_data_v[0] !== pd || m_last_v[0] !== pl) begin
                            errors++;
                            $display("FAIL bp_stable: got v=%b d=%02h l=%b, expected v=1 d=%02h l=%b",
                                     m_valid_v[0], m_data_v[0], m_last_v[0], pd, pl);
                        end
                    end
                    pv = m_valid_v[0]; pr = m_ready_v[0]; pd = m_data_v[0]; pl = m_last_v[0];
                end
            end
        join
        checks++;
        if (!ok_a || !ok_b || !ok_c || !ok) begin
            errors++;
            $display("FAIL bp_random_progress: got feed=%b%b%b drain=%b, expected 1111", ok_a, ok_b, ok_c, ok);
        end

        m_ready_v[0] = 1'b0;
        feed(0, ramp(8'h40), 16, 0, ok_a, st);
        feed(0, ramp(8'h50), 16, 0, ok_b, st);
        early = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_ready_v[0] !== 1'b0 || m_valid_v[0] !== 1'b1) early = 1;
        end
        checks++;
        if (!ok_a || !ok_b || early) begin
            errors++;
            $display("FAIL bp_both_full: got feed=%b%b s_ready=%b m_valid=%b, expected s_ready=0 m_valid=1",
                     ok_a, ok_b, s_ready_v[0], m_valid_v[0]);
        end
        @(posedge clk);
        #1;
        m_ready_v[0] = 1'b1;
        fires = 0;
        for (int i = 0; i < 40 && fires < 16; i++) begin
            @(negedge clk);
            if (m_valid_v[0]) fires++;
            if (s_ready_v[0]) early = 1;
        end
        @(negedge clk);
        checks++;
        if (fires != 16 || early || s_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got fires=%0d early=%0b s_ready=%b, expected 16 0 1", fires, early, s_ready_v[0]);
        end
        wait_drain(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending, expected 0", expq0.size()); end
    endtask

    task automatic test_reset_mid;
        bit ok, hit;
        int st, bad;
        m_ready_v[0] = 1'b1;
        feed(0, ramp(8'h80), 7, 0, ok, st);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid_v[0] !== 1'b0 || s_ready_v[0] !== 1'b0 || m_data_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_in: got m_valid=%b s_ready=%b m_data=%02h, expected 0 0 00", m_valid_v[0], s_ready_v[0], m_data_v[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        feed(0, ramp(8'h90), 16, 0, ok, st);
        hit = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(posedge clk);
            #1;
            if (obs0.size() >= 5) hit = 1;
        end
        reset = 1'b1;
        expq0.delete();
        @(negedge clk);
        checks++;
        if (!hit || m_valid_v[0] !== 1'b0 || s_ready_v[0] !== 1'b0 || m_last_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out: got hit=%0b m_valid=%b s_ready=%b m_last=%b, expected 1 0 0 0",
                     hit, m_valid_v[0], s_ready_v[0], m_last_v[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs0.delete();
        @(negedge clk);
        checks++;
        if (s_ready_v[0] !== 1'b1 || m_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got s_ready=%b m_valid=%b, expected 1 0", s_ready_v[0], m_valid_v[0]);
        end
        @(posedge clk);
        #1;
        feed(0, ramp(0), 16, 0, ok, st);
        wait_drain(0, ok);
        bad = 0;
        for (int i = 0; i < 16; i++) if (i >= obs0.size() || obs0[i] !== basic_exp[i]) bad++;
        checks++;
        if (!ok || bad != 0 || obs0.size() != 16) begin
            errors++;
            $display("FAIL rst_mid_clean: got %0d bytes, %0d wrong, expected 16 matching", obs0.size(), bad);
        end
    endtask

    task automatic test_num_buf1;
        bit ok1, ok2, ok;
        int st1, st2, bad;
        m_ready_v[1] = 1'b1;
        obs1.delete();
        feed(1, ramp(0), 16, 0, ok1, st1);
        feed(1, ramp(8'h70), 16, 0, ok2, st2);
        checks++;
        if (!ok1 || !ok2 || st2 != 16) begin
            errors++;
            $display("FAIL nb1_stall: got %0d s_ready-low cycles, expected 16", st2);
        end
        wait_drain(1, ok);
        bad = 0;
        for (int i = 0; i < 16; i++) if (i >= obs1.size() || obs1[i] !== basic_exp[i]) bad++;
        checks++;
        if (!ok || bad != 0 || obs1.size() != 32) begin
            errors++;
            $display("FAIL nb1_data: got %0d bytes, %0d wrong in first block, expected 32 and 0", obs1.size(), bad);
        end
    endtask

`ifdef SR_FWD_MODE_EN
    task automatic test_round_trip;
        bit ok;
        int st, bad;
        blk_t back;
        m_ready_v[0] = 1'b1;
        obs0.delete();
        feed(0, ramp(0), 16, 1, ok, st);
        wait_drain(0, ok);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            back[i] = (i < obs0.size()) ? obs0[i] : 8'hxx;
            if (i >= obs0.size() || obs0[i] !== fwd_exp[i]) bad++;
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL rt_forward: got %0d wrong bytes, expected 0", bad);
        end
        obs0.delete();
        feed(0, back, 16, 0, ok, st);
        wait_drain(0, ok);
        bad = 0;
        for (int i = 0; i < 16; i++) if (i >= obs0.size() || obs0[i] !== 8'(i)) bad++;
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL rt_inverse: got %0d wrong bytes, expected 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_num_buf1;
`ifdef SR_FWD_MODE_EN
        test_round_trip;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
